// File: rtl/fifo_sync_param.sv
// fifo_sync_param: single-clock FIFO with arbitrary depth, occupancy/threshold flags and response pulses.
// Define FIFO_FWFT_EN for first-word-fall-through output; otherwise reads are registered.
module fifo_sync_param #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int AF_LEVEL   = 7,
    parameter int AE_LEVEL   = 1,
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1,
    localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FIFO_WIDTH-1:0] data_in,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [FIFO_WIDTH-1:0] data_out,
    output logic                  rd_valid,
    output logic                  wr_ack,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  full,
    output logic                  empty,
    output logic                  almostfull,
    output logic                  almostempty,
    output logic [CW-1:0]         count
);
    logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic wr_ack_q, overflow_q, underflow_q;
    logic rd_acc, wr_acc;

    assign full        = count_q == CW'(FIFO_DEPTH);
    assign empty       = count_q == '0;
    assign almostfull  = count_q >= CW'(AF_LEVEL);
    assign almostempty = count_q <= CW'(AE_LEVEL);
    assign count       = count_q;
    assign wr_ack      = wr_ack_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;
    // A read frees a slot in the same cycle, so a full FIFO can still take a write alongside it.
    assign rd_acc      = rd_en && !empty;
    assign wr_acc      = wr_en && (!full || rd_acc);

    always_comb begin
        wr_ptr_d = wr_acc ? ((wr_ptr_q == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1)) : wr_ptr_q;
        rd_ptr_d = rd_acc ? ((rd_ptr_q == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1)) : rd_ptr_q;
        count_d  = count_q + CW'(wr_acc) - CW'(rd_acc);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            wr_ack_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            wr_ack_q    <= wr_acc;
            overflow_q  <= wr_en && !wr_acc;
            underflow_q <= rd_en && !rd_acc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_acc) mem_q[wr_ptr_q] <= data_in;
    end

`ifdef FIFO_FWFT_EN
    assign data_out = mem_q[rd_ptr_q];
    assign rd_valid = !empty;
`else
    logic [FIFO_WIDTH-1:0] data_out_q, data_out_d;
    logic rd_valid_q;

    assign data_out   = data_out_q;
    assign rd_valid   = rd_valid_q;
    assign data_out_d = rd_acc ? mem_q[rd_ptr_q] : data_out_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out_q <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            data_out_q <= data_out_d;
            rd_valid_q <= rd_acc;
        end
    end
`endif
endmodule

// File: tb/tb_fifo_sync_param.sv
// tb_fifo_sync_param: scoreboard bench for a depth-8 and a depth-5 FIFO instance.
module tb_fifo_sync_param;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] data_in = '0;
    logic        wr_en = 1'b0, rd_en = 1'b0;
    logic        sel = 1'b0;
    logic [15:0] dout8, dout5;
    logic        rv8, ack8, ovf8, udf8, full8, empty8, af8, ae8;
    logic        rv5, ack5, ovf5, udf5, full5, empty5, af5, ae5;
    logic [3:0]  cnt8;
    logic [2:0]  cnt5;
    logic [15:0] sb[$];
    logic [15:0] last_out = '0;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    fifo_sync_param #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .AF_LEVEL(7), .AE_LEVEL(1)) u_dut8 (
        .clk(clk), .rst(rst), .data_in(data_in), .wr_en(wr_en && !sel), .rd_en(rd_en && !sel),
        .data_out(dout8), .rd_valid(rv8), .wr_ack(ack8), .overflow(ovf8), .underflow(udf8),
        .full(full8), .empty(empty8), .almostfull(af8), .almostempty(ae8), .count(cnt8));

    fifo_sync_param #(.FIFO_WIDTH(16), .FIFO_DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1)) u_dut5 (
        .clk(clk), .rst(rst), .data_in(data_in), .wr_en(wr_en && sel), .rd_en(rd_en && sel),
        .data_out(dout5), .rd_valid(rv5), .wr_ack(ack5), .overflow(ovf5), .underflow(udf5),
        .full(full5), .empty(empty5), .almostfull(af5), .almostempty(ae5), .count(cnt5));

    wire [15:0] o_dout = sel ? dout5 : dout8;
    wire [3:0]  o_cnt  = sel ? {1'b0, cnt5} : cnt8;
    wire        o_rv   = sel ? rv5 : rv8;
    wire        o_ack  = sel ? ack5 : ack8;
    wire        o_ovf  = sel ? ovf5 : ovf8;
    wire        o_udf  = sel ? udf5 : udf8;
    wire        o_full = sel ? full5 : full8;
    wire        o_emp  = sel ? empty5 : empty8;
    wire        o_af   = sel ? af5 : af8;
    wire        o_ae   = sel ? ae5 : ae8;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_flags(input string tag);
        int n, depth, af;
        n = sb.size();
        depth = sel ? 5 : 8;
        af = sel ? 4 : 7;
        chk({tag, ".count"}, 32'(o_cnt), 32'(n));
        chk({tag, ".full"}, 32'(o_full), 32'(n == depth));
        chk({tag, ".empty"}, 32'(o_emp), 32'(n == 0));
        chk({tag, ".afull"}, 32'(o_af), 32'(n >= af));
        chk({tag, ".aempty"}, 32'(o_ae), 32'(n <= 1));
    endtask

    task automatic do_reset(input bit w);
        rst = 1'b1;
        wr_en = w;
        rd_en = 1'b0;
        data_in = 16'hDEAD;
        @(posedge clk);
        #1;
        rst = 1'b0;
        wr_en = 1'b0;
        sb.delete();
        last_out = '0;
        chk_flags("rst");
        chk("rst.wr_ack", 32'(o_ack), 0);
        chk("rst.overflow", 32'(o_ovf), 0);
        chk("rst.underflow", 32'(o_udf), 0);
        chk("rst.rd_valid", 32'(o_rv), 0);
`ifndef FIFO_FWFT_EN
        chk("rst.data_out", 32'(o_dout), 0);
`endif
    endtask

    task automatic cycle(input bit w, input bit r, input logic [15:0] d);
        bit racc, wacc;
        logic [15:0] head;
        int depth;
        depth = sel ? 5 : 8;
        racc = r && sb.size() > 0;
        wacc = w && (sb.size() < depth || racc);
        wr_en = w;
        rd_en = r;
        data_in = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        head = racc ? sb.pop_front() : 16'h0;
        if (wacc) sb.push_back(d);
        chk_flags("cyc");
        chk("cyc.wr_ack", 32'(o_ack), 32'(wacc));
        chk("cyc.overflow", 32'(o_ovf), 32'(w && !wacc));
        chk("cyc.underflow", 32'(o_udf), 32'(r && !racc));
`ifdef FIFO_FWFT_EN
        chk("fwft.rd_valid", 32'(o_rv), 32'(sb.size() > 0));
        if (sb.size() > 0) chk("fwft.data_out", 32'(o_dout), 32'(sb[0]));
`else
        chk("rd.rd_valid", 32'(o_rv), 32'(racc));
        if (racc) last_out = head;
        chk("rd.data_out", 32'(o_dout), 32'(last_out));
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        @(posedge clk);
        #1;
        rst = 1'b0;
        do_reset(1'b0);
        for (int i = 1; i <= 3; i++) cycle(1, 0, 16'(i));
        do_reset(1'b1);
        for (int i = 1; i <= 8; i++) cycle(1, 0, 16'(i));
        cycle(1, 0, 16'h0009);
        cycle(1, 1, 16'h00FF);
        for (int i = 0; i < 8; i++) cycle(0, 1, 16'h0);
        cycle(0, 1, 16'h0);
        cycle(1, 1, 16'h1234);
        cycle(0, 1, 16'h0);
        for (int i = 0; i < 300; i++)
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), 16'($urandom));
        for (int i = 0; i < 10; i++) cycle(0, 1, 16'h0);
        sel = 1'b1;
        do_reset(1'b0);
        for (int i = 10; i <= 14; i++) cycle(1, 0, 16'(i));
        cycle(1, 0, 16'h0099);
        for (int i = 0; i < 3; i++) cycle(0, 1, 16'h0);
        for (int i = 15; i <= 17; i++) cycle(1, 0, 16'(i));
        cycle(1, 1, 16'h0077);
        for (int i = 0; i < 6; i++) cycle(0, 1, 16'h0);
        for (int i = 0; i < 200; i++)
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
